axi_lite_reg_frontend: RTL

AXI_LITE_REG_FRONTEND -- requirements
Module: axi_lite_reg_frontend

---
 rtl/axi_lite_reg_frontend.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_frontend.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_frontend
//
// AXI-Lite slave front end for a small bank of 32-bit registers.
// Writes go to shadow registers that drive the IP. Reads return capture
// registers that the IP loads. Writes and reads use separate state machines.
//
// Parameters
//   ADDR_W    AXI-Lite address width in bits (at least 5).
//   NUM_REGS  number of registers (at most 4), at byte offsets 0x0, 0x4, 0x8, ...
//
// Ports
//   clk_i, rst_ni           clock (rising edge), asynchronous active-low reset
//   s_aw*/s_w*/s_b*         AXI-Lite write address, write data, write response
//   s_ar*/s_r*              AXI-Lite read address, read data
//   reg2ip_data_o           shadow register contents driven to the IP
//   reg2ip_we_o             one-cycle write strobe per register
//   ip2reg_data_i           status data from the IP
//   ip2reg_valid_i          per-register capture enable for the status data
//
// Build option
//   AXI_REG_FRONTEND_WSTRB_EN  When defined, only the bytes selected by
//                              s_wstrb_i are merged into the shadow register.
//                              When undefined, the full word is written.
// ---------------------------------------------------------------------------
module axi_lite_reg_frontend #(
    parameter int ADDR_W   = 8,
    parameter int NUM_REGS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [ADDR_W-1:0]        s_awaddr_i,
    input  logic                     s_awvalid_i,
    output logic                     s_awready_o,
    input  logic [31:0]              s_wdata_i,
    input  logic [3:0]               s_wstrb_i,
    input  logic                     s_wvalid_i,
    output logic                     s_wready_o,
    output logic [1:0]               s_bresp_o,
    output logic                     s_bvalid_o,
    input  logic                     s_bready_i,
    input  logic [ADDR_W-1:0]        s_araddr_i,
    input  logic                     s_arvalid_i,
    output logic                     s_arready_o,
    output logic [31:0]              s_rdata_o,
    output logic [1:0]               s_rresp_o,
    output logic                     s_rvalid_o,
    input  logic                     s_rready_i,
    output logic [NUM_REGS-1:0][31:0] reg2ip_data_o,
    output logic [NUM_REGS-1:0]      reg2ip_we_o,
    input  logic [NUM_REGS-1:0][31:0] ip2reg_data_i,
    input  logic [NUM_REGS-1:0]      ip2reg_valid_i
);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // An address is mapped when it is word aligned, its upper bits are zero,
    // and its index addr[3:2] is below NUM_REGS.
    function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
        return (addr[ADDR_W-1:4] == '0) && (addr[1:0] == 2'b00) &&
               (int'(addr[3:2]) < NUM_REGS);
    endfunction

    w_state_e                   w_state_q, w_state_d;
    r_state_e                   r_state_q, r_state_d;
    logic                       rdy_en_q;   // keeps the ready outputs low until the first edge after reset
    logic                       aw_got_q, w_got_q;
    logic [ADDR_W-1:0]          awaddr_q;
    logic [31:0]                wdata_q;
    logic [1:0]                 bresp_q;
    logic [NUM_REGS-1:0][31:0]  shadow_q, cap_q, wr_merged;
    logic [31:0]                rdata_q, rd_sel;
    logic [1:0]                 rresp_q;
    logic                       aw_hs, w_hs, ar_hs, wr_mapped;

`ifdef AXI_REG_FRONTEND_WSTRB_EN
    logic [3:0]                 wstrb_q;
`else
    logic                       unused_wstrb;
    assign unused_wstrb = ^s_wstrb_i;
`endif

    assign aw_hs     = s_awvalid_i && s_awready_o;
    assign w_hs      = s_wvalid_i && s_wready_o;
    assign ar_hs     = s_arvalid_i && s_arready_o;
    assign wr_mapped = is_mapped(awaddr_q);

    // ------------------------------------------------------------ write FSM
    // NOTE: state and data registers use non-blocking assignments so that
    // every flop samples values from before the clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            rdy_en_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            rdy_en_q  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_d = W_EXEC;
            W_EXEC: w_state_d = W_RESP;
            W_RESP: if (s_bready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // The merged word is computed combinationally. The IP then sees the new
    // value in the same cycle as its write strobe, and the shadow register
    // takes that value at the end of W_EXEC.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_merged[i] = wdata_q;
`ifdef AXI_REG_FRONTEND_WSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (!wstrb_q[b]) wr_merged[i][8*b +: 8] = shadow_q[i][8*b +: 8];
            end
`endif
        end
    end

    always_comb begin
        s_awready_o = rdy_en_q && (w_state_q == W_IDLE) && !aw_got_q;
        s_wready_o  = rdy_en_q && (w_state_q == W_IDLE) && !w_got_q;
        s_bvalid_o  = (w_state_q == W_RESP);
        s_bresp_o   = bresp_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg2ip_we_o[i]   = (w_state_q == W_EXEC) && wr_mapped &&
                               (int'(awaddr_q[3:2]) == i);
            reg2ip_data_o[i] = reg2ip_we_o[i] ? wr_merged[i] : shadow_q[i];
        end
    end

    // NOTE: the shadow and capture banks are cleared by reset because the
    // IP and the read path both observe them right after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            bresp_q  <= RESP_OKAY;
            shadow_q <= '0;
`ifdef AXI_REG_FRONTEND_WSTRB_EN
            wstrb_q  <= '0;
`endif
        end else begin
            if (aw_hs) begin
                aw_got_q <= 1'b1;
                awaddr_q <= s_awaddr_i;
            end
            if (w_hs) begin
                w_got_q  <= 1'b1;
                wdata_q  <= s_wdata_i;
`ifdef AXI_REG_FRONTEND_WSTRB_EN
                wstrb_q  <= s_wstrb_i;
`endif
            end
            if (w_state_q == W_EXEC) begin
                aw_got_q <= 1'b0;
                w_got_q  <= 1'b0;
                bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (reg2ip_we_o[i]) shadow_q[i] <= wr_merged[i];
                end
            end
        end
    end

    // ------------------------------------------------------------- read FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state_q <= R_IDLE;
        else         r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_DATA;
            R_DATA: if (s_rready_i) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_arready_o = rdy_en_q && (r_state_q == R_IDLE);
        s_rvalid_o  = (r_state_q == R_DATA);
        s_rdata_o   = rdata_q;
        s_rresp_o   = rresp_q;
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(s_araddr_i[3:2]) == i) rd_sel = cap_q[i];
        end
    end

    // A read that coincides with a capture to the same index still sees the
    // old contents, because the read sample and the capture load share one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ip2reg_valid_i[i]) cap_q[i] <= ip2reg_data_i[i];
            end
            if (ar_hs) begin
                rdata_q <= is_mapped(s_araddr_i) ? rd_sel : 32'h0;
                rresp_q <= is_mapped(s_araddr_i) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
